// File: rtl/montinv_pkg.sv
// Shared definitions for the montinv_arb inverse-engine arbiter: state encoding,
// default engine widths and the watchdog limit formula.
package montinv_pkg;

  localparam int WIDTH_DEF = 256;
  localparam int CWID_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The engine needs at most 2*WIDTH iterations; the margin covers its pipeline.
  function automatic int tmo_cyc(input int width);
    return 2 * width + 32;
  endfunction

endpackage

// File: rtl/montinv_arb_rr_pick.sv
// Combinational round-robin priority encoder: returns the first requester at or
// after ptr, wrapping modulo NREQ.
module montinv_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            hit
);

  logic [IW-1:0] cand;
  int            sum;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    sum  = 0;
    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IW'(sum);
      if (req[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/montinv_arb.sv
// Round-robin arbiter and sequencer for one shared almost-Montgomery-inverse engine.
// Optional watchdog on the engine wait enabled by defining MONTINV_TIMEOUT_EN.
module montinv_arb
  import montinv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CWID    = CWID_DEF,
  parameter int NREQ    = 4,
  parameter int TMO_CYC = tmo_cyc(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] req_din,
  input  logic [NREQ*WIDTH-1:0] req_mod,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [WIDTH-1:0]     res,
  output logic [CWID-1:0]      res_exp,
  output logic                 err,
  output logic                 busy,
  output logic                 inv_en,
  output logic [WIDTH-1:0]     inv_din,
  output logic [WIDTH-1:0]     inv_mod,
  input  logic [WIDTH-1:0]     inv_ainv,
  input  logic [CWID-1:0]      inv_exp,
  input  logic                 inv_vld
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, ptr, pick_idx;
  logic            pick_hit;
  logic [WIDTH-1:0] sel_din, sel_mod;
  logic            bad_op;
  logic            err_q;
  logic            tmo_hit;
  logic [NREQ-1:0] idx_oh;

  montinv_arb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .hit (pick_hit)
  );

  assign sel_din = req_din[int'(pick_idx) * WIDTH +: WIDTH];
  assign sel_mod = req_mod[int'(pick_idx) * WIDTH +: WIDTH];
  // The engine only converges for an odd modulus and 0 < a < p.
  assign bad_op  = (sel_din == '0) || !sel_mod[0] || (sel_din >= sel_mod);
  assign idx_oh  = NREQ'(1) << idx;
  assign busy    = (state != IDLE);

`ifdef MONTINV_TIMEOUT_EN
  logic [CWID+1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + (CWID+2)'(1);
    end
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == (CWID+2)'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inv_en    = 1'b0;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    unique case (state)
      IDLE:   if (pick_hit) state_nxt = bad_op ? DONE : LAUNCH;
      LAUNCH: begin
        inv_en    = 1'b1;
        gnt       = idx_oh;
        state_nxt = WAIT;
      end
      WAIT: begin
        gnt = idx_oh;
        if (inv_vld || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        done      = idx_oh;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      ptr     <= '0;
      inv_din <= '0;
      inv_mod <= '0;
      res     <= '0;
      res_exp <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pick_hit) begin
          idx     <= pick_idx;
          inv_din <= sel_din;
          inv_mod <= sel_mod;
          err_q   <= bad_op;
        end
        WAIT: if (inv_vld) begin
          res     <= inv_ainv;
          res_exp <= inv_exp;
          err_q   <= 1'b0;
        end else if (tmo_hit) begin
          res     <= '0;
          res_exp <= '1;
          err_q   <= 1'b1;
        end
        DONE: ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montinv_arb.sv
// Self-checking bench for montinv_arb: a transaction-level model of the arbiter,
// a behavioural inverse engine, directed scenarios and a randomized request phase.
module tb_montinv_arb;
  import montinv_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 5;
  localparam int NR  = 4;
  localparam int TMO = tmo_cyc(W);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*W-1:0]   req_din = '0;
  logic [NR*W-1:0]   req_mod = '0;
  logic [NR-1:0]     gnt, done;
  logic [W-1:0]      res;
  logic [CW-1:0]     res_exp;
  logic              err, busy, inv_en;
  logic [W-1:0]      inv_din, inv_mod;
  logic [W-1:0]      inv_ainv = '0;
  logic [CW-1:0]     inv_exp = '0;
  logic              inv_vld = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_en     = 0;
  int n_done   = 0;
  bit eng_on   = 1'b1;
  int stray_cnt = 0;

  always #5 clk = ~clk;

  montinv_arb #(.WIDTH(W), .CWID(CW), .NREQ(NR), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_din(req_din), .req_mod(req_mod),
    .gnt(gnt), .done(done), .res(res), .res_exp(res_exp), .err(err), .busy(busy),
    .inv_en(inv_en), .inv_din(inv_din), .inv_mod(inv_mod),
    .inv_ainv(inv_ainv), .inv_exp(inv_exp), .inv_vld(inv_vld)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Kaliski phase 1: returns r = a^-1 * 2^k mod p and k.
  function automatic void kaliski(input int a, input int p, output int r, output int k);
    int u, v, s, guard;
    u = p; v = a; s = 1; r = 0; k = 0; guard = 0;
    while (v > 0 && guard < 64) begin
      if (u % 2 == 0)      begin u = u / 2;       s = 2 * s; end
      else if (v % 2 == 0) begin v = v / 2;       r = 2 * r; end
      else if (u > v)      begin u = (u - v) / 2; r = r + s; s = 2 * s; end
      else                 begin v = (v - u) / 2; s = s + r; r = 2 * r; end
      k++;
      guard++;
    end
    if (r >= p) r = r - p;
    r = p - r;
  endfunction

  function automatic longint pow2_mod(input int k, input int p);
    longint x;
    x = 1;
    for (int i = 0; i < k; i++) x = (x * 2) % p;
    return x;
  endfunction

  // Behavioural engine: answers each launch after a random delay unless switched off.
  initial begin : engine
    int cd, stray_seen, r, k;
    cd = -1; stray_seen = 0; r = 0; k = 0;
    forever begin
      @(negedge clk);
      inv_vld = 1'b0;
      if (!eng_on) cd = -1;
      if (stray_seen != stray_cnt) begin
        stray_seen++;
        inv_vld  = 1'b1;
        inv_ainv = W'($urandom);
        inv_exp  = CW'($urandom);
      end else if (cd == 0) begin
        inv_vld  = 1'b1;
        inv_ainv = W'(r);
        inv_exp  = CW'(k);
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end else if (inv_en && eng_on) begin
        kaliski(int'(inv_din), int'(inv_mod), r, k);
        cd = int'($urandom_range(0, 4));
      end
    end
  end

  // Transaction model: one job at a time, tracked by its age in clock edges.
  initial begin : scoreboard
    logic [NR-1:0]   rq;
    logic [NR*W-1:0] dn, md;
    logic            vs, rs;
    logic [W-1:0]    as, m_res;
    logic [CW-1:0]   es, m_exp;
    logic [NR-1:0]   e_gnt, e_done;
    bit              job, fin, jerr;
    int              jidx, age, ptr, jdin, jmod, c;
    job = 0; fin = 0; jerr = 0; jidx = 0; age = 0; ptr = 0; jdin = 0; jmod = 0; c = 0;
    m_res = '0; m_exp = '0;
    forever begin
      @(posedge clk);
      rq = req; dn = req_din; md = req_mod; vs = inv_vld; as = inv_ainv; es = inv_exp; rs = rst_n;
      #1;
      if (!rs) begin
        job = 0; fin = 0; jerr = 0; ptr = 0; m_res = '0; m_exp = '0;
      end else if (!job) begin
        if (rq != '0) begin
          for (int i = 0; i < NR; i++) begin
            c = (ptr + i) % NR;
            if (rq[c]) begin jidx = c; break; end
          end
          job  = 1; age = 0;
          jdin = int'(dn[jidx*W +: W]);
          jmod = int'(md[jidx*W +: W]);
          jerr = (jdin == 0) || (jmod % 2 == 0) || (jdin >= jmod);
          fin  = jerr;
        end
      end else if (fin) begin
        job = 0;
        ptr = (jidx + 1) % NR;
      end else begin
        age++;
        if (age >= 2 && vs) begin
          fin = 1; m_res = as; m_exp = es;
        end
`ifdef MONTINV_TIMEOUT_EN
        else if (age == TMO + 1) begin
          fin = 1; jerr = 1; m_res = '0; m_exp = '1;
        end
`endif
      end
      e_gnt  = (job && !fin) ? (NR'(1) << jidx) : '0;
      e_done = (job && fin)  ? (NR'(1) << jidx) : '0;
      check("gnt",     gnt,     e_gnt);
      check("done",    done,    e_done);
      check("busy",    busy,    job);
      check("inv_en",  inv_en,  job && !fin && age == 0);
      check("err",     err,     job && fin && jerr);
      check("res",     res,     m_res);
      check("res_exp", res_exp, m_exp);
      if (job && !fin) begin
        check("inv_din", inv_din, jdin);
        check("inv_mod", inv_mod, jmod);
      end
      if (done != '0 && !err)
        check("inverse_law", (longint'(res) * jdin) % jmod, pow2_mod(int'(res_exp), jmod));
      if (inv_en) n_en++;
      if (done != '0) n_done++;
    end
  end

  task automatic set_op(input int i, input int a, input int p);
    req_din[i*W +: W] = W'(a);
    req_mod[i*W +: W] = W'(p);
  endtask

  task automatic wait_done(input int lim);
    bit ok;
    ok = 0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (done != '0) begin ok = 1; break; end
    end
    check("wait_done", ok, 1'b1);
  endtask

  function automatic int oh_index(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic rand_op(input int i);
    int primes [8];
    int p, a;
    primes = '{3, 17, 23, 97, 131, 199, 241, 251};
    p = primes[$urandom_range(0, 7)];
    case ($urandom_range(0, 11))
      0:       a = 0;
      1:       begin a = int'($urandom_range(1, 2)); p = p + 1; end
      2:       a = p + int'($urandom_range(0, 255 - p));
      default: a = int'($urandom_range(1, p - 1));
    endcase
    set_op(i, a, p);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad_a [3];
    int bad_p [3];
    int en0, d0, wc;
    logic [W-1:0]  r0;
    logic [CW-1:0] e0;
    bit ok;
    bad_a = '{0, 5, 30};
    bad_p = '{23, 22, 23};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {gnt, done, busy, inv_en, err}, '0);
    check("rst_data", {res, res_exp}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness from pointer 0: all four requesters held high.
    set_op(0, 3, 23); set_op(1, 7, 97); set_op(2, 100, 251); set_op(3, 2, 17);
    req = '1;
    for (int n = 0; n < 5; n++) begin
      wait_done(60);
      check("fair_order", oh_index(done), n % NR);
      if (n == 4) req = '0;
    end
    repeat (2) @(negedge clk);

    // Single request with a hand-computed answer: 14 * 2^6 mod 23 = 22.
    en0 = n_en;
    set_op(0, 5, 23);
    req = 4'b0001;
    wait_done(40);
    check("single_done", done, 4'b0001);
    check("single_err", err, 1'b0);
    check("single_res", res, 8'd22);
    check("single_exp", res_exp, 5'd6);
    check("single_exp_range", (res_exp >= 5) && (res_exp <= 10), 1'b1);
    req = '0;
    @(negedge clk);
    check("single_en_count", n_en - en0, 1);

    // Invalid operands are rejected without touching the engine.
    for (int k = 0; k < 3; k++) begin
      en0 = n_en;
      set_op(1, bad_a[k], bad_p[k]);
      req = 4'b0010;
      wait_done(10);
      check("bad_done", done, 4'b0010);
      check("bad_err", err, 1'b1);
      req = '0;
      @(negedge clk);
      check("bad_no_en", n_en - en0, 0);
    end

    // Stray engine valid while idle.
    repeat (2) @(negedge clk);
    r0 = res; e0 = res_exp; d0 = n_done;
    stray_cnt++;
    repeat (4) @(negedge clk);
    check("stray_res", {res, res_exp}, {r0, e0});
    check("stray_no_done", n_done - d0, 0);

    // Asynchronous reset while waiting on the engine.
    eng_on = 1'b0;
    set_op(2, 9, 131);
    req = 4'b0100;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt[2] && !inv_en) begin ok = 1; break; end
    end
    check("reach_wait", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {gnt, done, busy, inv_en, err, res, res_exp}, '0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eng_on = 1'b1;
    set_op(2, 5, 23);
    req = 4'b0100;
    wait_done(40);
    check("post_rst_done", done, 4'b0100);
    check("post_rst_res", {err, res, res_exp}, {1'b0, 8'd22, 5'd6});
    req = '0;
    repeat (2) @(negedge clk);

`ifdef MONTINV_TIMEOUT_EN
    // Silent engine: the watchdog ends the wait after TMO cycles.
    eng_on = 1'b0;
    set_op(3, 5, 23);
    req = 4'b1000;
    wc = 0;
    for (int c = 0; c < TMO + 20; c++) begin
      @(negedge clk);
      if (done != '0) break;
      if (gnt[3] && !inv_en) wc++;
    end
    check("tmo_wait_cycles", wc, TMO);
    check("tmo_done", {done, err}, {4'b1000, 1'b1});
    check("tmo_res", {res, res_exp}, {8'd0, 5'h1f});
    req = '0;
    eng_on = 1'b1;
    repeat (2) @(negedge clk);
`endif

    // Randomized traffic; the scoreboard checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (done[i] && (cyc >= 2800 || $urandom_range(0, 2) != 0)) req[i] = 1'b0;
        end else if (cyc < 2800 && $urandom_range(0, 5) == 0) begin
          rand_op(i);
          req[i] = 1'b1;
        end
      end
    end
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("drain_idle", ok, 1'b1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
